// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states and grant encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with a starvation guard and timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [1:0]          grant
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic gnt_d, gnt_i, done_ok, done_to, fin;
  always_comb begin
    gnt_d = state == IDLE && d_req && (!i_req || starve < SW'(STARVE_MAX));
    gnt_i = state == IDLE && i_req && !gnt_d;
    done_ok = state == BUS && mem_ready;
    done_to = state == BUS && !mem_ready && cnt == CW'(TIMEOUT);
    fin = done_ok || done_to;
    state_nxt = (gnt_d || gnt_i) ? BUS : fin ? DONE : state == DONE ? IDLE : state;
  end
  // mem_en decoded from state so an asynchronous reset drops it without a clock edge
  assign mem_en = state == BUS;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      starve <= '0;
      grant <= GNT_NONE;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      if (gnt_d || gnt_i) begin
        mem_we <= gnt_d && d_we;
        mem_be <= gnt_d ? d_be : '1;
        mem_addr <= gnt_d ? d_addr : i_addr;
        mem_wdata <= gnt_d ? d_wdata : '0;
        grant <= gnt_d ? GNT_D : GNT_I;
        cnt <= CW'(1);
      end
      if (gnt_d) starve <= !i_req ? '0 : starve == SW'(STARVE_MAX) ? starve : starve + SW'(1);
      if (gnt_i) starve <= '0;
      if (state == BUS && !fin) cnt <= cnt + CW'(1);
      i_ack <= fin && grant == GNT_I;
      d_ack <= fin && grant == GNT_D;
      i_err <= done_to && grant == GNT_I;
      d_err <= done_to && grant == GNT_D;
      if (fin && grant == GNT_I) i_rdata <= done_ok ? mem_rdata : '0;
      if (fin && grant == GNT_D) d_rdata <= done_ok ? mem_rdata : '0;
      if (state == DONE) grant <= GNT_NONE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of the memory port arbiter
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst;
  logic i_req, d_req, d_we, i_ack, i_err, d_ack, d_err, mem_en, mem_we, mem_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] d_be, mem_be;
  logic [1:0] grant;
  int checks = 0, failures = 0;
  int starve_m = 0;
  logic [31:0] exp_ir = 0, exp_dr = 0;
  bit i_pend = 0, d_pend = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_gnt"}, grant, 0);
    chk({tag, "_acks"}, {i_ack, d_ack}, 0);
  endtask

  // One arbitration opportunity: pick requests, predict the winner, walk its access to completion
  task automatic run_round(input int i_mode, input int d_mode);
    bit win_d;
    int lat, nb;
    logic [31:0] e_addr, e_wdata, got_data, e_rd;
    logic [3:0] e_be;
    logic e_we, e_err;
    logic [1:0] e_gnt;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (!i_pend) begin
      i_req = i_mode == 1 ? 1'b1 : i_mode == 2 ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      i_addr = $urandom;
    end
    if (!d_pend) begin
      d_req = d_mode == 1 ? 1'b1 : d_mode == 2 ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      d_we = 1'($urandom);
      d_be = 4'($urandom);
      d_addr = $urandom;
      d_wdata = $urandom;
    end
    if (!i_req && !d_req) begin
      tick;
      chk_idle("noreq");
      return;
    end
    win_d = d_req && (!i_req || starve_m < STARVE_MAX);
    if (win_d) starve_m = i_req ? (starve_m + 1 > STARVE_MAX ? STARVE_MAX : starve_m + 1) : 0;
    else starve_m = 0;
    e_gnt = win_d ? 2'b10 : 2'b01;
    e_addr = win_d ? d_addr : i_addr;
    e_we = win_d ? d_we : 1'b0;
    e_be = win_d ? d_be : 4'hF;
    e_wdata = d_wdata;
    lat = $urandom_range(0, 7) == 0 ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4) : $urandom_range(1, 5);
    nb = lat > TIMEOUT ? TIMEOUT : lat;
    got_data = 0;
    tick;
    chk("gnt", grant, e_gnt);
    chk("gnt_en", mem_en, 1);
    chk("gnt_addr", mem_addr, e_addr);
    chk("gnt_we", mem_we, e_we);
    chk("gnt_be", mem_be, e_be);
    if (win_d) chk("gnt_wdata", mem_wdata, e_wdata);
    for (int k = 1; k <= nb; k++) begin
      mem_ready = k == lat;
      mem_rdata = $urandom;
      if (k == lat) got_data = mem_rdata;
      tick;
      if (k < nb) begin
        chk("bus_en", mem_en, 1);
        chk("bus_addr", mem_addr, e_addr);
        chk("bus_acks", {i_ack, d_ack}, 0);
      end
    end
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    e_err = lat > TIMEOUT;
    e_rd = e_err ? 32'd0 : got_data;
    if (win_d) exp_dr = e_rd;
    else exp_ir = e_rd;
    chk("done_acks", {i_ack, d_ack}, win_d ? 2'b01 : 2'b10);
    chk("done_err", win_d ? d_err : i_err, e_err);
    chk("done_irdata", i_rdata, exp_ir);
    chk("done_drdata", d_rdata, exp_dr);
    chk("done_en", mem_en, 0);
    chk("done_gnt", grant, e_gnt);
    i_pend = i_req && win_d;
    d_pend = d_req && !win_d;
    tick;
    chk_idle("post");
  endtask

  initial begin
    rst = 1;
    {i_req, d_req, d_we, mem_ready} = '0;
    {i_addr, d_addr, d_wdata, mem_rdata} = '0;
    d_be = '0;
    #2;
    chk_idle("rst");
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk);
    rst = 0;
    run_round(1, 2);
    run_round(1, 1);
    run_round(2, 2);
    for (int r = 0; r < 8; r++) run_round(1, 1);
    for (int r = 0; r < 300; r++) run_round(0, 0);
    i_pend = 0;
    d_pend = 0;
    i_req = 0;
    d_req = 1;
    d_we = 0;
    mem_ready = 0;
    tick;
    chk("mid_en", mem_en, 1);
    tick;
    #2;
    rst = 1;
    #1;
    chk_idle("async_rst");
    chk("async_rdata", {i_rdata, d_rdata}, 0);
    chk("async_addr", mem_addr, 0);
    d_req = 0;
    exp_ir = 0;
    exp_dr = 0;
    starve_m = 0;
    @(negedge clk);
    rst = 0;
    run_round(1, 2);
    for (int r = 0; r < 7; r++) run_round(1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
